// File: rtl/rv_div_if.sv
// rtl/rv_div_if.sv - request/response bundle between the execute stage and the divider
`timescale 1ns/1ps

interface rv_div_if #(
    parameter int WIDTH = 32
);
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] dividend_i;
    logic [WIDTH-1:0] divisor_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             busy_o;

    modport master (
        output flush_i, req_valid_i, op_i, dividend_i, divisor_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, result_o, busy_o
    );

    modport slave (
        input  flush_i, req_valid_i, op_i, dividend_i, divisor_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, result_o, busy_o
    );
endinterface

// File: rtl/rv_div_unit.sv
// rtl/rv_div_unit.sv - iterative restoring divider for RISC-V DIV/DIVU/REM/REMU
`timescale 1ns/1ps

module rv_div_unit #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    rv_div_if.slave  div_if
);
    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_cfg
        $error("rv_div_unit: WIDTH must be a multiple of BITS_PER_CYCLE");
    end

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e           state_q, state_d;
    logic             is_rem_q, is_rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   rem_v, trial_v;
    logic [WIDTH-1:0] quo_v, q_fin, r_fin;

    // Only signed ops take the magnitude; op_i[0]==0 marks DIV/REM.
    assign a_neg = ~div_if.op_i[0] & div_if.dividend_i[WIDTH-1];
    assign b_neg = ~div_if.op_i[0] & div_if.divisor_i[WIDTH-1];
    assign a_mag = a_neg ? -div_if.dividend_i : div_if.dividend_i;
    assign b_mag = b_neg ? -div_if.divisor_i  : div_if.divisor_i;

    always_comb begin
        rem_v = rem_q;
        quo_v = quo_q;
        trial_v = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            rem_v   = {rem_v[WIDTH-1:0], quo_v[WIDTH-1]};
            quo_v   = {quo_v[WIDTH-2:0], 1'b0};
            trial_v = rem_v - {1'b0, dvs_q};
            if (!trial_v[WIDTH]) begin
                rem_v    = trial_v;
                quo_v[0] = 1'b1;
            end
        end
        q_fin = q_neg_q ? -quo_v : quo_v;
        r_fin = r_neg_q ? -rem_v[WIDTH-1:0] : rem_v[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        is_rem_d = is_rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (div_if.req_valid_i && !div_if.flush_i) begin
                    is_rem_d = div_if.op_i[1];
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    quo_d    = a_mag;
                    rem_d    = '0;
                    dvs_d    = b_mag;
                    cnt_d    = CW'(ITER);
                    if (div_if.divisor_i == '0) begin
                        result_d = div_if.op_i[1] ? div_if.dividend_i : '1;
                        state_d  = DONE;
                    end else if (!div_if.op_i[0] && div_if.dividend_i == MIN_NEG &&
                                 div_if.divisor_i == '1) begin
                        result_d = div_if.op_i[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                quo_d = quo_v;
                rem_d = rem_v;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    result_d = is_rem_q ? r_fin : q_fin;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (div_if.rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A pipeline flush discards whatever is in flight, including a pending result.
        if (div_if.flush_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            is_rem_q <= is_rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign div_if.req_ready_o = (state_q == IDLE) && !div_if.flush_i;
    assign div_if.rsp_valid_o = (state_q == DONE);
    assign div_if.busy_o      = (state_q != IDLE);
    assign div_if.result_o    = result_q;
endmodule

// File: tb/tb_rv_div_unit.sv
// tb/tb_rv_div_unit.sv - directed and randomised checks of rv_div_unit at 32/1 and 64/4
`timescale 1ns/1ps

module tb_rv_div_unit;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    rv_div_if #(.WIDTH(32)) if32 ();
    rv_div_if #(.WIDTH(64)) if64 ();

    rv_div_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .div_if(if32)
    );
    rv_div_unit #(.WIDTH(64), .BITS_PER_CYCLE(4)) dut64 (
        .clk_i(clk), .rst_ni(rst_n), .div_if(if64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic do_op32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat);
        @(negedge clk);
        if32.op_i = op; if32.dividend_i = a; if32.divisor_i = b; if32.req_valid_i = 1'b1;
        @(posedge clk); #1;
        if32.req_valid_i = 1'b0;
        lat = 1;
        while (!if32.rsp_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = if32.result_o;
        @(posedge clk); #1;
    endtask

    task automatic do_op64(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] res, output int lat);
        @(negedge clk);
        if64.op_i = op; if64.dividend_i = a; if64.divisor_i = b; if64.req_valid_i = 1'b1;
        @(posedge clk); #1;
        if64.req_valid_i = 1'b0;
        lat = 1;
        while (!if64.rsp_valid_o && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = if64.result_o;
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] model64(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
        logic signed [63:0] sa, sb;
        sa = a; sb = b;
        if (b == 64'd0) return op[1] ? a : {64{1'b1}};
        case (op)
            2'd0: return (a == MIN64 && b == {64{1'b1}}) ? MIN64 : 64'(sa / sb);
            2'd1: return a / b;
            2'd2: return (a == MIN64 && b == {64{1'b1}}) ? 64'd0 : 64'(sa % sb);
            default: return a % b;
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (if32.rsp_valid_o !== 1'b0 || if32.busy_o !== 1'b0 || if32.result_o !== 32'd0) begin
            $display("FAIL reset_outputs got valid=%b busy=%b result=%h exp 0/0/0",
                     if32.rsp_valid_o, if32.busy_o, if32.result_o);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (if32.req_ready_o !== 1'b1) begin
            $display("FAIL reset_ready got=%b exp=1", if32.req_ready_o);
            failures++;
        end
    endtask

    task automatic test_unsigned();
        logic [31:0] r; int lat;
        do_op32(2'b01, 32'd100, 32'd7, r, lat);
        checks++;
        if (r !== 32'd14) begin $display("FAIL divu_100_7 got=%h exp=%h", r, 32'd14); failures++; end
        checks++;
        if (lat !== 33) begin $display("FAIL divu_latency got=%0d exp=33", lat); failures++; end
        do_op32(2'b11, 32'd100, 32'd7, r, lat);
        checks++;
        if (r !== 32'd2) begin $display("FAIL remu_100_7 got=%h exp=%h", r, 32'd2); failures++; end
        do_op32(2'b01, 32'hFFFF_FFFF, 32'd2, r, lat);
        checks++;
        if (r !== 32'h7FFF_FFFF) begin $display("FAIL divu_max_2 got=%h exp=7fffffff", r); failures++; end
    endtask

    task automatic test_signed();
        logic [31:0] r; int lat;
        do_op32(2'b00, -32'sd7, 32'd2, r, lat);
        checks++;
        if (r !== 32'hFFFF_FFFD) begin $display("FAIL div_m7_2 got=%h exp=fffffffd", r); failures++; end
        do_op32(2'b10, -32'sd7, 32'd2, r, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF) begin $display("FAIL rem_m7_2 got=%h exp=ffffffff", r); failures++; end
        do_op32(2'b10, 32'd7, -32'sd2, r, lat);
        checks++;
        if (r !== 32'd1) begin $display("FAIL rem_7_m2 got=%h exp=1", r); failures++; end
    endtask

    task automatic test_div_zero();
        logic [31:0] r; int lat;
        do_op32(2'b00, 32'd5, 32'd0, r, lat);
        checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1) begin
            $display("FAIL div_5_0 got=%h lat=%0d exp=ffffffff lat=1", r, lat); failures++;
        end
        do_op32(2'b11, 32'd5, 32'd0, r, lat);
        checks++;
        if (r !== 32'd5 || lat !== 1) begin
            $display("FAIL remu_5_0 got=%h lat=%0d exp=5 lat=1", r, lat); failures++;
        end
        do_op32(2'b10, -32'sd5, 32'd0, r, lat);
        checks++;
        if (r !== 32'hFFFF_FFFB || lat !== 1) begin
            $display("FAIL rem_m5_0 got=%h lat=%0d exp=fffffffb lat=1", r, lat); failures++;
        end
    endtask

    task automatic test_overflow();
        logic [31:0] r; int lat;
        do_op32(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++;
        if (r !== 32'h8000_0000 || lat !== 1) begin
            $display("FAIL div_overflow got=%h lat=%0d exp=80000000 lat=1", r, lat); failures++;
        end
        do_op32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
        checks++;
        if (r !== 32'd0 || lat !== 1) begin
            $display("FAIL rem_overflow got=%h lat=%0d exp=0 lat=1", r, lat); failures++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        if32.rsp_ready_i = 1'b0;
        if32.op_i = 2'b01; if32.dividend_i = 32'd100; if32.divisor_i = 32'd7; if32.req_valid_i = 1'b1;
        @(posedge clk); #1;
        if32.req_valid_i = 1'b0;
        n = 0;
        while (!if32.rsp_valid_o && n < 200) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (if32.rsp_valid_o !== 1'b1 || if32.result_o !== 32'd14 ||
                if32.req_ready_o !== 1'b0 || if32.busy_o !== 1'b1) begin
                $display("FAIL backpressure_hold cyc=%0d got valid=%b res=%h ready=%b busy=%b exp 1/0000000e/0/1",
                         i, if32.rsp_valid_o, if32.result_o, if32.req_ready_o, if32.busy_o);
                failures++;
            end
        end
        @(negedge clk);
        if32.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (if32.busy_o !== 1'b0) begin $display("FAIL backpressure_release busy got=%b exp=0", if32.busy_o); failures++; end
    endtask

    task automatic test_flush();
        logic [31:0] r; int lat; int seen;
        @(negedge clk);
        if32.op_i = 2'b01; if32.dividend_i = 32'd1000; if32.divisor_i = 32'd3; if32.req_valid_i = 1'b1;
        @(posedge clk); #1;
        if32.req_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        if32.flush_i = 1'b1;
        #1;
        checks++;
        if (if32.req_ready_o !== 1'b0) begin $display("FAIL flush_ready got=%b exp=0", if32.req_ready_o); failures++; end
        @(posedge clk); #1;
        if32.flush_i = 1'b0;
        checks++;
        if (if32.busy_o !== 1'b0 || if32.rsp_valid_o !== 1'b0) begin
            $display("FAIL flush_idle got busy=%b valid=%b exp 0/0", if32.busy_o, if32.rsp_valid_o); failures++;
        end
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (if32.rsp_valid_o) seen++; end
        checks++;
        if (seen !== 0) begin $display("FAIL flush_no_rsp got=%0d valid cycles exp=0", seen); failures++; end
        do_op32(2'b01, 32'd9, 32'd3, r, lat);
        checks++;
        if (r !== 32'd3) begin $display("FAIL divu_9_3_after_flush got=%h exp=3", r); failures++; end
    endtask

    task automatic test_w64_random();
        logic [63:0] a, b, r, exp; logic [1:0] op; int lat, explat, bad;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: a = MIN64;
                1: a = 64'($urandom_range(0, 1000));
                default: a = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 7))
                0: b = 64'd0;
                1: b = {64{1'b1}};
                2: b = 64'($urandom_range(1, 100));
                3: b = -64'($urandom_range(1, 100));
                default: b = {$urandom, $urandom} >> $urandom_range(0, 63);
            endcase
            exp = model64(op, a, b);
            explat = (b == 64'd0 || (!op[0] && a == MIN64 && b == {64{1'b1}})) ? 1 : 17;
            do_op64(op, a, b, r, lat);
            checks++;
            if (r !== exp || lat !== explat) begin
                if (bad < 10)
                    $display("FAIL w64_op op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d",
                             op, a, b, r, lat, exp, explat);
                bad++;
                failures++;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        if64.op_i = 2'b01; if64.dividend_i = 64'd12345; if64.divisor_i = 64'd7; if64.req_valid_i = 1'b1;
        @(posedge clk); #1;
        if64.req_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        checks++;
        if (if64.busy_o !== 1'b1) begin $display("FAIL async_pre_busy got=%b exp=1", if64.busy_o); failures++; end
        rst_n = 1'b0;
        #1;
        checks++;
        if (if64.rsp_valid_o !== 1'b0 || if64.busy_o !== 1'b0 || if64.result_o !== 64'd0) begin
            $display("FAIL async_reset got valid=%b busy=%b res=%h exp 0/0/0",
                     if64.rsp_valid_o, if64.busy_o, if64.result_o);
            failures++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (if64.rsp_valid_o !== 1'b0) begin $display("FAIL async_no_partial got=%b exp=0", if64.rsp_valid_o); failures++; end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        if32.flush_i = 1'b0; if32.req_valid_i = 1'b0; if32.op_i = 2'b00;
        if32.dividend_i = '0; if32.divisor_i = '0; if32.rsp_ready_i = 1'b1;
        if64.flush_i = 1'b0; if64.req_valid_i = 1'b0; if64.op_i = 2'b00;
        if64.dividend_i = '0; if64.divisor_i = '0; if64.rsp_ready_i = 1'b1;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_backpressure();
        test_flush();
        test_w64_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
